// File: rtl/reg_file_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// reg_file_access_ctrl_if
// Client-side request/response bus of the register-file access controller.
//   master : client driving requests, observing responses and busy
//   slave  : the controller accepting requests, producing responses and busy
// Signals:
//   req_valid/req_ready  request handshake (accepted when both are 1)
//   req_op               00 READ_PAIR, 01 WRITE, 10 CLEAR_ALL, 11 illegal
//   req_addr_a/b/w       read-port A/B and write addresses
//   req_data             write data
//   rsp_valid            one-cycle completion pulse (no backpressure)
//   rsp_err              qualifies rsp_valid; 1 for an illegal op
//   rsp_data1/2          last captured read data
//   busy                 controller is not idle
// -----------------------------------------------------------------------------
interface reg_file_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr_a;
    logic [ADDR_WIDTH-1:0] req_addr_b;
    logic [ADDR_WIDTH-1:0] req_addr_w;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data1;
    logic [DATA_WIDTH-1:0] rsp_data2;
    logic                  busy;

    modport master (
        output req_valid, req_op, req_addr_a, req_addr_b, req_addr_w, req_data,
        input  req_ready, rsp_valid, rsp_err, rsp_data1, rsp_data2, busy
    );

    modport slave (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_addr_w, req_data,
        output req_ready, rsp_valid, rsp_err, rsp_data1, rsp_data2, busy
    );
endinterface

// File: rtl/reg_file_access_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_access_ctrl
// Sequences client requests onto a register file: paired read, single write,
// sweep-clear of REG_COUNT registers, and an error response for the illegal op.
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset
//   bus              reg_file_access_ctrl_if.slave (request/response/busy)
//   o_rf_read        register-file read strobe
//   o_rf_write       register-file write strobe
//   o_rf_addr_r1/r2  read addresses (latched request A/B)
//   o_rf_addr_w      write address (latched request W, or sweep index)
//   o_rf_data_w      write data (latched request data, or 0 while clearing)
//   i_rf_data_r1/r2  read data, valid combinationally while o_rf_read=1
// Optional build macro:
//   R0_HARDWIRE_EN   register 0 reads as zero and is never written
// -----------------------------------------------------------------------------
module reg_file_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    reg_file_access_ctrl_if.slave bus,
    output logic                  o_rf_read,
    output logic                  o_rf_write,
    output logic [ADDR_WIDTH-1:0] o_rf_addr_r1,
    output logic [ADDR_WIDTH-1:0] o_rf_addr_r2,
    output logic [ADDR_WIDTH-1:0] o_rf_addr_w,
    output logic [DATA_WIDTH-1:0] o_rf_data_w,
    input  logic [DATA_WIDTH-1:0] i_rf_data_r1,
    input  logic [DATA_WIDTH-1:0] i_rf_data_r2
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_CLR, S_RSP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_addr_w;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_data1;
    logic [DATA_WIDTH-1:0] r_rsp_data2;

    logic                  w_ready;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_rsp_valid;
    logic                  w_rsp_err;
    logic                  w_rf_read;
    logic                  w_rf_write;
    logic [ADDR_WIDTH-1:0] w_rf_addr_w;
    logic [DATA_WIDTH-1:0] w_rf_data_w;
    logic                  w_wr_en;
    logic                  w_clr_en;
    logic [DATA_WIDTH-1:0] w_rd_in  [2];
    logic [DATA_WIDTH-1:0] w_rd_cap [2];

    // Register 0 may be hardwired: suppress its write strobes (the operation
    // still completes with normal timing) and force its read value to zero.
`ifdef R0_HARDWIRE_EN
    assign w_wr_en  = (r_addr_w != '0);
    assign w_clr_en = (r_cnt != '0);
`else
    assign w_wr_en  = 1'b1;
    assign w_clr_en = 1'b1;
`endif

    assign w_rd_in[0] = i_rf_data_r1;
    assign w_rd_in[1] = i_rf_data_r2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef R0_HARDWIRE_EN
        logic [ADDR_WIDTH-1:0] w_port_addr;
        assign w_port_addr  = (gi == 0) ? r_addr_a : r_addr_b;
        assign w_rd_cap[gi] = (w_port_addr == '0) ? '0 : w_rd_in[gi];
`else
        assign w_rd_cap[gi] = w_rd_in[gi];
`endif
    end

    // Ready is additionally gated by reset so no request is seen as accepted
    // while the controller is held in reset.
    assign w_accept = bus.req_valid & w_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b1;
        w_rsp_valid  = 1'b0;
        w_rsp_err    = 1'b0;
        w_rf_read    = 1'b0;
        w_rf_write   = 1'b0;
        w_rf_addr_w  = r_addr_w;
        w_rf_data_w  = r_data;
        case (r_state)
            S_IDLE: begin
                w_busy  = 1'b0;
                w_ready = i_rst_n;
                if (bus.req_valid) begin
                    case (bus.req_op)
                        2'b00:   w_state_next = S_RD;
                        2'b01:   w_state_next = S_WR;
                        2'b10:   w_state_next = S_CLR;
                        default: w_state_next = S_RSP;
                    endcase
                end
            end
            S_RD: begin
                w_rf_read    = 1'b1;
                w_state_next = S_RSP;
            end
            S_WR: begin
                w_rf_write   = w_wr_en;
                w_state_next = S_RSP;
            end
            S_CLR: begin
                w_rf_write  = w_clr_en;
                w_rf_addr_w = r_cnt;
                w_rf_data_w = '0;
                if (r_cnt == LAST_IDX) begin
                    w_state_next = S_RSP;
                end
            end
            S_RSP: begin
                w_rsp_valid  = 1'b1;
                w_rsp_err    = (r_op == 2'b11);
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op        <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_addr_w    <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_rsp_data1 <= '0;
            r_rsp_data2 <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= bus.req_op;
                r_addr_a <= bus.req_addr_a;
                r_addr_b <= bus.req_addr_b;
                r_addr_w <= bus.req_addr_w;
                r_data   <= bus.req_data;
                r_cnt    <= '0;
            end
            if (r_state == S_CLR) begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
            if (r_state == S_RD) begin
                r_rsp_data1 <= w_rd_cap[0];
                r_rsp_data2 <= w_rd_cap[1];
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.busy      = w_busy;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_err   = w_rsp_err;
    assign bus.rsp_data1 = r_rsp_data1;
    assign bus.rsp_data2 = r_rsp_data2;

    assign o_rf_read    = w_rf_read;
    assign o_rf_write   = w_rf_write;
    assign o_rf_addr_r1 = r_addr_a;
    assign o_rf_addr_r2 = r_addr_b;
    assign o_rf_addr_w  = w_rf_addr_w;
    assign o_rf_data_w  = w_rf_data_w;
endmodule

// File: tb/tb_reg_file_access_ctrl.sv
module tb_reg_file_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic          err;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          rf_read, rf_write;
    logic [AW-1:0] rf_addr_r1, rf_addr_r2, rf_addr_w;
    logic [DW-1:0] rf_data_w, rf_data_r1, rf_data_r2;
    logic [DW-1:0] mem [32];

    reg_file_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus),
        .o_rf_read    (rf_read),
        .o_rf_write   (rf_write),
        .o_rf_addr_r1 (rf_addr_r1),
        .o_rf_addr_r2 (rf_addr_r2),
        .o_rf_addr_w  (rf_addr_w),
        .o_rf_data_w  (rf_data_w),
        .i_rf_data_r1 (rf_data_r1),
        .i_rf_data_r2 (rf_data_r2)
    );

    // Register-file model: combinational read, write on the rising edge.
    assign rf_data_r1 = mem[rf_addr_r1];
    assign rf_data_r2 = mem[rf_addr_r2];
    always @(posedge clk) if (rf_write) mem[rf_addr_w] <= rf_data_w;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rb_bad = 0;
    int rd_cnt = 0;
    exp_t exp_q[$];
    int acc_q[$];
    int acc_hist[$];
    logic [AW+DW-1:0] wlog[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input int lat);
        exp_t e;
        e.err = err; e.d1 = d1; e.d2 = d2; e.lat = lat;
        return e;
    endfunction

    // Monitor: records acceptances and RF strobes, pops the scoreboard on rsp_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_valid && bus.req_ready) begin
                acc_q.push_back(cyc + 1);
                acc_hist.push_back(cyc + 1);
            end
            if (bus.req_ready == bus.busy) rb_bad++;
            if (rf_write) wlog.push_back({rf_addr_w, rf_data_w});
            if (rf_read) rd_cnt++;
            if (rf_read || rf_write)
                chk("strobe_exclusive", {62'd0, rf_read & rf_write, bus.rsp_valid}, 64'd0);
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    int a;
                    e = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    chk("rsp_data1", 64'(bus.rsp_data1), 64'(e.d1));
                    chk("rsp_data2", 64'(bus.rsp_data2), 64'(e.d2));
                    chk("rsp_latency", 64'(cyc + 1 - a), 64'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] w, input logic [DW-1:0] d, input bit push,
                         input exp_t e, input bit hold);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.req_op = op; bus.req_addr_a = a; bus.req_addr_b = b;
        bus.req_addr_w = w; bus.req_data = d; bus.req_valid = 1'b1;
        if (push) exp_q.push_back(e);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("rsp_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] m1, m2;
        bit hit;
        m1 = '0; m2 = '0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr_a = '0;
        bus.req_addr_b = '0; bus.req_addr_w = '0; bus.req_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_strobes", {62'd0, rf_read, rf_write}, 64'd0);
        chk("rst_addrs", 64'({rf_addr_r1, rf_addr_r2, rf_addr_w}), 64'd0);
        chk("rst_data", 64'(bus.rsp_data1 | bus.rsp_data2 | rf_data_w), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(bus.req_ready), 64'd1);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // WRITE 5 <- DEADBEEF
        wlog.delete();
        issue(2'b01, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        wait_done();
        chk("wr_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() != 0) chk("wr_entry", 64'(wlog[0]), 64'({5'd5, 32'hDEADBEEF}));

        issue(2'b01, 5'd0, 5'd0, 5'd7, 32'h12345678, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        wait_done();

        // READ_PAIR 5,7
        rd_cnt = 0;
        m1 = 32'hDEADBEEF; m2 = 32'h12345678;
        issue(2'b00, 5'd5, 5'd7, 5'd0, 32'd0, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        wait_done();
        chk("rd_count", 64'(rd_cnt), 64'd1);

        // Illegal op: error, no strobes, data unchanged
        wlog.delete(); rd_cnt = 0;
        issue(2'b11, 5'd1, 5'd2, 5'd3, 32'h55555555, 1'b1, mk(1'b1, m1, m2, 1), 1'b0);
        wait_done();
        chk("ill_no_write", 64'(wlog.size()), 64'd0);
        chk("ill_no_read", 64'(rd_cnt), 64'd0);

        // Back-to-back: valid held across RSP
        acc_hist.delete();
        issue(2'b01, 5'd0, 5'd0, 5'd9, 32'hCAFEF00D, 1'b1, mk(1'b0, m1, m2, 2), 1'b1);
        m1 = 32'hCAFEF00D; m2 = 32'hDEADBEEF;
        issue(2'b00, 5'd9, 5'd5, 5'd0, 32'd0, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        wait_done();
        chk("b2b_accepts", 64'(acc_hist.size()), 64'd2);
        if (acc_hist.size() == 2) chk("b2b_gap", 64'(acc_hist[1] - acc_hist[0]), 64'd3);

        // CLEAR_ALL
        wlog.delete();
        issue(2'b10, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, mk(1'b0, m1, m2, 33), 1'b0);
        wait_done();
        begin
            int first;
`ifdef R0_HARDWIRE_EN
            first = 1;
`else
            first = 0;
`endif
            chk("clr_count", 64'(wlog.size()), 64'(32 - first));
            for (int i = 0; i < wlog.size(); i++)
                chk("clr_entry", 64'(wlog[i]), 64'({5'(i + first), 32'd0}));
        end
        m1 = 32'd0; m2 = 32'd0;
        issue(2'b00, 5'd9, 5'd31, 5'd0, 32'd0, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        wait_done();

        // Reset during CLR at index 10
        issue(2'b01, 5'd0, 5'd0, 5'd12, 32'h0BADF00D, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        issue(2'b01, 5'd0, 5'd0, 5'd3, 32'h33333333, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        wait_done();
        issue(2'b10, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, mk(1'b0, m1, m2, 0), 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rf_write && rf_addr_w == 5'd10) begin hit = 1'b1; break; end
        end
        chk("clr_idx10_seen", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_strobes", {62'd0, rf_read, rf_write}, 64'd0);
        chk("mid_rst_addr_w", 64'(rf_addr_w), 64'd0);
        chk("mid_rst_rsp", 64'(bus.rsp_valid), 64'd0);
        acc_q.delete(); wlog.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        m1 = 32'd0; m2 = 32'h0BADF00D;
        issue(2'b00, 5'd3, 5'd12, 5'd0, 32'd0, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        wait_done();

        // Address 0 behaviour
        wlog.delete();
        issue(2'b01, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
        wait_done();
`ifdef R0_HARDWIRE_EN
        chk("r0_no_write", 64'(wlog.size()), 64'd0);
        m1 = 32'd0; m2 = 32'd0;
        issue(2'b00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
`else
        chk("r0_write", 64'(wlog.size()), 64'd1);
        m1 = 32'hFFFFFFFF; m2 = 32'h0BADF00D;
        issue(2'b00, 5'd0, 5'd12, 5'd0, 32'd0, 1'b1, mk(1'b0, m1, m2, 2), 1'b0);
`endif
        wait_done();

        chk("ready_vs_busy", 64'(rb_bad), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
